// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default resolution/counter widths and the capture FSM state type.
package pwm_pkg;

   localparam int unsigned PWM_R        = 8;
   localparam int unsigned PWM_CNT_BITS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: quot = floor(dividend * 2^R / divisor), one quotient bit per cycle,
// saturated to 2^R. The final bit is resolved combinationally so done_c/quot_c appear R+1 cycles after start.
module pwm_duty_div
   import pwm_pkg::*;
#(
   parameter int unsigned R        = PWM_R,
   parameter int unsigned CNT_BITS = PWM_CNT_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [CNT_BITS-1:0] dividend,
   input  logic [CNT_BITS-1:0] divisor,
   output logic                busy,
   output logic                done_c,
   output logic [R:0]          quot_c
);

   localparam int unsigned SW     = $clog2(R + 1);
   localparam int unsigned DUTY_W = R + 1;
   localparam logic [R:0]  FULL   = DUTY_W'(1) << R;

   logic [CNT_BITS:0]   rem;
   logic [CNT_BITS-1:0] div;
   logic [R-1:0]        q;
   logic [SW-1:0]       step;

   logic                ge;
   logic [CNT_BITS-1:0] rem_sub;
   logic [R:0]          raw;

   // One restoring step: compare, conditionally subtract, shift the quotient bit in.
   always_comb begin
      ge      = rem >= {1'b0, div};
      rem_sub = ge ? CNT_BITS'(rem - {1'b0, div}) : rem[CNT_BITS-1:0];
      raw     = {q, ge};
      done_c  = busy && !abort && (step == SW'(R));
      quot_c  = (raw[R] && (|raw[R-1:0])) ? FULL : raw;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0;
         rem  <= '0;
         div  <= '0;
         q    <= '0;
         step <= '0;
      end else if (abort) begin
         busy <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         rem  <= {1'b0, dividend};
         div  <= divisor;
         q    <= '0;
         step <= '0;
      end else if (busy) begin
         rem  <= {rem_sub, 1'b0};
         q    <= raw[R-1:0];
         step <= step + 1'b1;
         if (step == SW'(R)) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM measurement stage: synchronizes pwm_in, times rise-to-rise and rise-to-fall intervals,
// and converts them into a duty code in the generator's 0..2^R units.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned R           = PWM_R,
   parameter int unsigned CNT_BITS    = PWM_CNT_BITS,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                pwm_in,
   output logic [CNT_BITS-1:0] period_out,
   output logic [CNT_BITS-1:0] high_out,
   output logic [R:0]          duty_out,
   output logic                valid,
   output logic                stuck_high,
   output logic                stuck_low,
   output logic                overrun
);

   localparam int unsigned         DUTY_W  = R + 1;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [R:0]          FULL    = DUTY_W'(1) << R;

   cap_state_e state, state_next;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level, level_d, rise, fall;
   logic                   en_d;

   logic [CNT_BITS-1:0] period_cnt, high_cnt;
   logic                fell;

   logic                cnt_restart, cap_normal, cap_timeout, to_high;
   logic [CNT_BITS-1:0] low_high, cap_high;

   logic                div_start, div_busy, div_done_c;
   logic [R:0]          div_quot_c;
   logic [CNT_BITS-1:0] pend_period, pend_high;

   // Synchronizer plus edge-detect flop; strobes come from the synchronized level only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         level_d <= 1'b0;
         en_d    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         level_d <= level;
         en_d    <= en;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~level_d;
   assign fall  = ~level & level_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Edge-timing FSM: a rise in LOW is a normal capture, a saturated period counter is a timeout.
   always_comb begin
      state_next  = state;
      cnt_restart = 1'b0;
      cap_normal  = 1'b0;
      cap_timeout = 1'b0;
      to_high     = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_next  = HIGH;
               cnt_restart = 1'b1;
            end
         end
         HIGH: begin
            if (fall) state_next = LOW;
            if (period_cnt == CNT_MAX) begin
               cap_timeout = 1'b1;
               to_high     = !fall;
               cnt_restart = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_next  = HIGH;
               cap_normal  = 1'b1;
               cnt_restart = 1'b1;
            end else if (period_cnt == CNT_MAX) begin
               cap_timeout = 1'b1;
               cnt_restart = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (!en) begin
         state_next  = IDLE;
         cnt_restart = 1'b0;
         cap_normal  = 1'b0;
         cap_timeout = 1'b0;
      end
   end

   // high_cnt freezes at the fall; until a fall is seen since the last restart the high time is 0.
   assign low_high  = (fell || fall) ? high_cnt : '0;
   assign cap_high  = to_high ? CNT_MAX : low_high;
   assign div_start = cap_normal && !div_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_cnt <= '0;
         high_cnt   <= '0;
         fell       <= 1'b0;
      end else if (state_next == IDLE) begin
         period_cnt <= '0;
         high_cnt   <= '0;
         fell       <= 1'b0;
      end else if (cnt_restart) begin
         period_cnt <= CNT_BITS'(1);
         high_cnt   <= CNT_BITS'(1);
         fell       <= 1'b0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
         if (state == HIGH) begin
            if (fall) fell     <= 1'b1;
            else      high_cnt <= high_cnt + 1'b1;
         end
      end
   end

   pwm_duty_div #(
      .R        (R),
      .CNT_BITS (CNT_BITS)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .abort    (!en),
      .dividend (low_high),
      .divisor  (period_cnt),
      .busy     (div_busy),
      .done_c   (div_done_c),
      .quot_c   (div_quot_c)
   );

   // Result registers: timeouts publish immediately, normal captures when the divider finishes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_period <= '0;
         pend_high   <= '0;
         period_out  <= '0;
         high_out    <= '0;
         duty_out    <= '0;
         valid       <= 1'b0;
         stuck_high  <= 1'b0;
         stuck_low   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (div_start) begin
            pend_period <= period_cnt;
            pend_high   <= low_high;
         end
         if (cap_timeout) begin
            period_out <= CNT_MAX;
            high_out   <= cap_high;
            duty_out   <= to_high ? FULL : '0;
            valid      <= 1'b1;
            stuck_high <= to_high;
            stuck_low  <= !to_high;
         end else if (div_done_c) begin
            period_out <= pend_period;
            high_out   <= pend_high;
            duty_out   <= div_quot_c;
            valid      <= 1'b1;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
         end
         if (en_d && !en)                 overrun <= 1'b0;
         else if (cap_normal && div_busy) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: pin-level interval model feeds expected results to a valid-driven monitor.
module tb_pwm_capture;

   localparam int R   = 8;
   localparam int CB  = 12;
   localparam int MAX = (1 << CB) - 1;

   typedef struct {
      int cyc;
      int period;
      int high;
      int duty;
      int sh;
      int sl;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic          pwm_in = 1'b0;
   logic [CB-1:0] period_out, high_out;
   logic [R:0]    duty_out;
   logic          valid, stuck_high, stuck_low, overrun;

   pwm_capture #(.R(R), .CNT_BITS(CB), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .pwm_in     (pwm_in),
      .period_out (period_out),
      .high_out   (high_out),
      .duty_out   (duty_out),
      .valid      (valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   exp_t last;
   exp_t mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each valid pops one expectation; between valids the outputs must hold.
   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("latency",    cyc,               mon_e.cyc);
            chk("period_out", int'(period_out),  mon_e.period);
            chk("high_out",   int'(high_out),    mon_e.high);
            chk("duty_out",   int'(duty_out),    mon_e.duty);
            chk("stuck_high", int'(stuck_high),  mon_e.sh);
            chk("stuck_low",  int'(stuck_low),   mon_e.sl);
            last = mon_e;
         end
      end else if (period_out != CB'(last.period) || high_out != CB'(last.high) ||
                   duty_out != 9'(last.duty) || stuck_high != last.sh[0] ||
                   stuck_low != last.sl[0]) begin
         chk("hold_outputs", 1, 0);
      end
   end

   // Reference model state, in pin-time units (pin time k = drive after the k-th clock edge).
   bit m_prev  = 0;
   bit m_armed = 0;
   bit m_fell  = 0;
   bit m_ovr   = 0;
   int m_ref   = 0;
   int m_fall  = 0;
   int m_acc   = -1000;

   function automatic int duty_of(input int h, input int p);
      int d;
      d = (h * 256) / p;
      return (d > 256) ? 256 : d;
   endfunction

   task automatic push(input int c, input int p, input int h, input int d, input int sh, input int sl);
      exp_t e;
      e.cyc = c; e.period = p; e.high = h; e.duty = d; e.sh = sh; e.sl = sl;
      sb.push_back(e);
   endtask

   task automatic model(input int k, input bit v, input bit rise, input bit fall);
      int p, h;
      if (!m_armed) begin
         if (rise) begin
            m_armed = 1; m_ref = k; m_fell = 0;
         end
      end else if (rise) begin
         p = k - m_ref;
         h = m_fell ? (m_fall - m_ref) : 0;
         if (k - m_acc < R + 2) m_ovr = 1;
         else begin
            m_acc = k;
            push(k + R + 4, p, h, duty_of(h, p), 0, 0);
         end
         m_ref = k; m_fell = 0;
      end else begin
         if (fall) begin
            m_fell = 1; m_fall = k;
         end
         if (k - m_ref == MAX) begin
            h = v ? MAX : (m_fell ? (m_fall - m_ref) : 0);
            push(k + 3, MAX, h, v ? 256 : 0, v ? 1 : 0, v ? 0 : 1);
            m_ref = k; m_fell = 0;
         end
      end
   endtask

   task automatic step(input bit v);
      bit rise, fall;
      @(posedge clk); #1;
      rise   = v && !m_prev;
      fall   = !v && m_prev;
      pwm_in = v;
      m_prev = v;
      if (en) model(cyc, v, rise, fall);
      else    m_armed = 0;
   endtask

   task automatic pulse(input int p, input int h);
      for (int i = 0; i < p; i++) step(i < h);
   endtask

   task automatic set_en(input bit v);
      exp_t keep[$];
      @(posedge clk); #1;
      if (en && !v) begin
         m_ovr = 0; m_armed = 0; m_acc = -1000;
         foreach (sb[i]) if (sb[i].cyc <= cyc) keep.push_back(sb[i]);
         sb = keep;
      end
      en = v;
   endtask

   task automatic do_reset();
      exp_t zero;
      @(posedge clk); #1;
      reset  = 1'b1;
      pwm_in = 1'b0;
      m_prev = 0; m_armed = 0; m_fell = 0; m_ovr = 0; m_acc = -1000;
      sb.delete();
      zero = '{default: 0};
      last = zero;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"},  int'(period_out), 0);
      chk({tag, "_high"},    int'(high_out),   0);
      chk({tag, "_duty"},    int'(duty_out),   0);
      chk({tag, "_valid"},   int'(valid),      0);
      chk({tag, "_stuck_h"}, int'(stuck_high), 0);
      chk({tag, "_stuck_l"}, int'(stuck_low),  0);
      chk({tag, "_overrun"}, int'(overrun),    0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required < 1000000", $time);
      $fatal(1);
   end

   initial begin
      int p, h;
      last = '{default: 0};
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_zero("reset");

      set_en(1'b1);
      repeat (5) step(1'b0);

      // Fixed duties 64/128/192, then random intervals including ones short enough to overrun.
      repeat (4) pulse(144, 36);
      repeat (4) pulse(144, 72);
      repeat (4) pulse(144, 108);
      repeat (30) begin
         p = $urandom_range(200, 4);
         h = $urandom_range(p - 1, 1);
         pulse(p, h);
      end

      // Line stuck low: two timeouts, the second with no fall since the restart.
      repeat (2 * MAX + 50) step(1'b0);

      // Line stuck high, then normal pulses clear stuck_high.
      repeat (2) pulse(144, 72);
      repeat (MAX + 100) step(1'b1);
      repeat (3) pulse(144, 36);

      // Period shorter than the divider: drops and sticky overrun, cleared by an en pulse.
      repeat (10) pulse(4, 2);
      repeat (20) step(1'b0);
      chk("overrun_set", int'(overrun), int'(m_ovr));
      chk("overrun_is_one", int'(overrun), 1);
      set_en(1'b0);
      repeat (3) step(1'b0);
      chk("overrun_cleared", int'(overrun), int'(m_ovr));
      set_en(1'b1);
      repeat (3) step(1'b0);

      // Reset three cycles after the capturing rise strobe: the division is discarded.
      pulse(100, 40);
      repeat (6) step(1'b1);
      do_reset();
      @(negedge clk);
      chk_zero("mid_div_reset");
      repeat (20) step(1'b0);
      repeat (4) pulse(60, 20);

      for (int i = 0; i < 50 && sb.size() > 0; i++) step(1'b0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
